// File: rtl/vend_pkg.sv
// Shared vending-machine types: change dispenser state encoding and coin values in quarter units.
package vend_pkg;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_EJECT,
        DISP_GAP,
        DISP_DONE
    } disp_state_t;

    localparam int QTR_VAL  = 1;
    localparam int HALF_VAL = 2;

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter that parks at zero; o_expired marks the last cycle of a timed interval.
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer: accepts an owed amount in quarters and pulses the half-dollar and
// quarter ejectors one coin at a time, largest coin first, then pulses done.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int QW           = 3
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          req_valid,
    input  logic [QW-1:0] req_qtrs,
    output logic          req_ready,
    output logic          halfDollar_out,
    output logic          quarter_out,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] remaining
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [QW-1:0] HALF_Q     = QW'(HALF_VAL);
    localparam logic [QW-1:0] QTR_Q      = QW'(QTR_VAL);

    disp_state_t   r_state;
    logic [QW-1:0] r_remaining;
    logic          r_coin_half;
    logic          r_half;
    logic          r_qtr;
    logic          r_busy;
    logic          r_done;
    logic          r_ready;

    disp_state_t   w_state_nxt;
    logic [QW-1:0] w_remaining_nxt;
    logic          w_coin_half_nxt;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_expired;
    logic [QW-1:0] w_sel_src;
    logic          w_sel_half;
    logic [QW-1:0] w_sel_rem;

    pulse_timer #(.W(TW)) u_timer (
        .i_clk      (CLK),
        .i_rst      (RES),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // Coin choice for the next EJECT entry: from the fresh request in IDLE, else from what is still owed.
    assign w_sel_src  = (r_state == DISP_IDLE) ? req_qtrs : r_remaining;
    assign w_sel_half = (w_sel_src >= HALF_Q);
    assign w_sel_rem  = w_sel_src - (w_sel_half ? HALF_Q : QTR_Q);

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_half_nxt = r_coin_half;
        w_load          = 1'b0;
        w_load_val      = '0;
        case (r_state)
            DISP_IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    if (req_qtrs == '0) begin
                        w_state_nxt     = DISP_DONE;
                        w_remaining_nxt = '0;
                    end else begin
                        w_state_nxt     = DISP_EJECT;
                        w_load_val      = PULSE_LOAD;
                        w_coin_half_nxt = w_sel_half;
                        w_remaining_nxt = w_sel_rem;
                    end
                end
            end
            DISP_EJECT: begin
                if (w_expired) begin
                    w_load = 1'b1;
                    if (r_remaining != '0) begin
                        w_state_nxt = DISP_GAP;
                        w_load_val  = GAP_LOAD;
                    end else begin
                        w_state_nxt = DISP_DONE;
                    end
                end
            end
            DISP_GAP: begin
                if (w_expired) begin
                    w_state_nxt     = DISP_EJECT;
                    w_load          = 1'b1;
                    w_load_val      = PULSE_LOAD;
                    w_coin_half_nxt = w_sel_half;
                    w_remaining_nxt = w_sel_rem;
                end
            end
            DISP_DONE: begin
                w_state_nxt = DISP_IDLE;
                w_load      = 1'b1;
            end
            default: begin
                w_state_nxt = DISP_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state     <= DISP_IDLE;
            r_remaining <= '0;
            r_coin_half <= 1'b0;
            r_half      <= 1'b0;
            r_qtr       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coin_half <= w_coin_half_nxt;
            r_half      <= (w_state_nxt == DISP_EJECT) && w_coin_half_nxt;
            r_qtr       <= (w_state_nxt == DISP_EJECT) && !w_coin_half_nxt;
            r_busy      <= (w_state_nxt != DISP_IDLE);
            r_done      <= (w_state_nxt == DISP_DONE);
            r_ready     <= (w_state_nxt == DISP_IDLE);
        end
    end

    assign req_ready      = r_ready;
    assign halfDollar_out = r_half;
    assign quarter_out    = r_qtr;
    assign busy           = r_busy;
    assign done           = r_done;
    assign remaining      = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a coin-list model expands each accepted request into the
// per-cycle output picture it must produce; a monitor compares every cycle against it.
module tb_change_dispenser;

    localparam int P  = 4;
    localparam int G  = 2;
    localparam int QW = 3;
    localparam int W  = 8;
    // {req_ready, halfDollar_out, quarter_out, busy, done, remaining}
    localparam logic [W-1:0] IDLE_V = 8'b1000_0000;

    logic          CLK;
    logic          RES;
    logic          req_valid;
    logic [QW-1:0] req_qtrs;
    logic          req_ready;
    logic          halfDollar_out;
    logic          quarter_out;
    logic          busy;
    logic          done;
    logic [QW-1:0] remaining;

    logic [W-1:0] exp_q[$];
    logic         model_idle = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .QW           (QW)
    ) dut (
        .CLK            (CLK),
        .RES            (RES),
        .req_valid      (req_valid),
        .req_qtrs       (req_qtrs),
        .req_ready      (req_ready),
        .halfDollar_out (halfDollar_out),
        .quarter_out    (quarter_out),
        .busy           (busy),
        .done           (done),
        .remaining      (remaining)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] out_vec();
        return {req_ready, halfDollar_out, quarter_out, busy, done, remaining};
    endfunction

    // Reference: halves first, then the odd quarter; each coin is a pulse, gaps only between coins.
    task automatic push_expected(input logic [QW-1:0] q);
        int halves;
        int coins;
        int rem;
        logic is_half;
        logic [QW-1:0] rem_v;
        halves = int'(q) / 2;
        coins  = halves + int'(q) % 2;
        rem    = int'(q);
        for (int c = 0; c < coins; c++) begin
            is_half = (c < halves);
            rem     = rem - (is_half ? 2 : 1);
            rem_v   = QW'(rem);
            for (int k = 0; k < P; k++) exp_q.push_back({1'b0, is_half, !is_half, 1'b1, 1'b0, rem_v});
            if (c != coins - 1)
                for (int k = 0; k < G; k++) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rem_v});
        end
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {QW{1'b0}}});
    endtask

    // Present a request and keep it up until the model says the dispenser is idle at an edge.
    task automatic send(input logic [QW-1:0] v, input int gap);
        logic accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_qtrs  = v;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(posedge CLK);
            if (model_idle) accepted = 1'b1;
        end
        #1;
        vectors++;
        if (accepted) begin
            push_expected(v);
        end else begin
            miscompares++;
            $display("FAIL accept_timeout req=%0d ready=%b required acceptance within 100 cycles", v, req_ready);
        end
        if (gap > 0) begin
            req_valid = 1'b0;
            req_qtrs  = QW'($urandom_range(0, 7));
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    always @(negedge CLK) begin
        mon_act = out_vec();
        if (exp_q.size() == 0) begin
            mon_exp    = IDLE_V;
            model_idle = 1'b1;
        end else begin
            mon_exp    = exp_q.pop_front();
            model_idle = 1'b0;
        end
        vectors++;
        if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL cycle_vec t=%0t act=%b required=%b (ready,half,qtr,busy,done,rem)",
                     $time, mon_act, mon_exp);
        end
    end

    initial begin
        RES       = 1'b1;
        req_valid = 1'b0;
        req_qtrs  = '0;
        #23;
        RES = 1'b0;
        @(posedge CLK);
        #1;

        send(3'd3, 2);
        send(3'd0, 1);
        send(3'd7, 0);
        send(3'd5, 0);
        send(3'd2, 3);

        // Abort in the middle of the second half-dollar pulse of a 6-quarter request.
        send(3'd6, 0);
        req_valid = 1'b0;
        repeat (7) @(posedge CLK);
        #3;
        RES = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if (out_vec() !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_reset act=%b required=%b", out_vec(), IDLE_V);
        end
        @(posedge CLK);
        #3;
        RES = 1'b0;
        @(posedge CLK);
        #1;
        send(3'd1, 2);

        for (int i = 0; i < 20; i++) begin
            send(QW'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        req_valid = 1'b0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
        end
        repeat (3) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
